adder_mcc_pipe: RTL and testbench
=================================

Name: adder_mcc_pipe

Overview:
- Pipelined, parametrised successor to the combinational Manchester-carry-chain adder.
- Splits a WIDTH-bit add into NSEG = ceil(WIDTH/SEG_W) carry-chain segments, one register stage per segment; the carry is registered between segments, so each chain's timing is bounded by SEG_W bits, not WIDTH.
- Valid/ready handshake on both sides, external carry-in, full-rate throughput; sits between operand sources and the arithmetic result bus.

Parameters:
- WIDTH, `WIDTH, operand width in bits (>=1).
- SEG_W, 8, bits per carry-chain segment and pipeline stage (1..WIDTH).
- NSEG, derived localparam = ceil(WIDTH/SEG_W); not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH+1  result {carry_out, sum[WIDTH-1:0]}.
- busy  out  1  any pipeline stage holds a valid transaction.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: rst high at a rising edge clears all stage valid bits, out_valid=0, s=0. busy=0 and in_ready=1 in the following cycle. Reset mid-operation discards all in-flight transactions; none reach the output.
- Accept: a transaction is accepted at a rising edge where in_valid && in_ready.
- Ready: in_ready = !(out_valid && !out_ready). It is combinational from out_ready and registered out_valid only; there is no path from in_valid.
- Segment k (k=0..NSEG-1) covers bits [k*SEG_W, min((k+1)*SEG_W, WIDTH)-1]. The last segment is narrower when WIDTH % SEG_W != 0.
- Per-bit generate = x&y, propagate t = x|y, half-sum = x^y. Carry into bit i+1 is g[i] | (t[i] & c[i]).
- Carry into segment 0 is cin. Carry into segment k>0 is the registered carry-out of segment k-1 from the previous stage.
- Operand skew: segment k's x/y/half-sum bits are delayed k stages so they meet their incoming carry. Completed sum segments are de-skewed so all bits leave together.
- Latency: NSEG rising edges, counting the accept edge. out_valid is high in the cycle after the NSEG-th edge. NSEG=1 gives a single registered stage.
- Throughput: one transaction per cycle while out_ready=1. Results leave in acceptance order. Bubbles propagate and are not collapsed.
- Backpressure: while out_valid && !out_ready, every stage register (data and valid) holds. s and out_valid stay stable, and nothing is accepted or lost.
- Output handoff: when out_ready=1 and out_valid=1, the result is consumed at that edge. A new result, or out_valid=0, appears the next cycle according to the pipeline contents.
- Width rule: s[WIDTH] = final carry-out, s[WIDTH-1:0] = (x+y+cin) mod 2^WIDTH. No overflow flag.
- busy = OR of all stage valid bits including out_valid.

Optional Feature:
- Macro: ADDER_MCC_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with x/y at accept. sub=1 computes x + ~y + 1, with cin ignored; s[WIDTH] = 1 means no borrow (x >= y unsigned). sub=0 behaves exactly as the base add. sub is carried down the pipeline with its transaction.
- Undefined: no sub port, add-only, no extra logic.

Test Plan:
- Full carry ripple, WIDTH=32, SEG_W=8: x=0xFFFFFFFF, y=0x00000001, cin=0 -> s=0x1_00000000; out_valid exactly 4 cycles after accept.
- Streaming: accept (1,2,0), (0x80000000,0x80000000,0), (0xFFFF,0,1) on 3 consecutive cycles with out_ready=1 -> s=0x3, 0x1_00000000, 0x10000 on 3 consecutive cycles, in order.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 with in_valid held high -> s and out_valid stable, in_ready=0, no drop or duplicate after out_ready returns to 1.
- Reset mid-flight: accept 2 transactions, assert rst one cycle later -> out_valid never rises for them, busy=0 and s=0 after the reset edge, a fresh transaction afterwards completes normally.
- Odd width, WIDTH=13, SEG_W=5 (NSEG=3): x=0x1FFF, y=0x1FFF, cin=1 -> s=0x3FFF, latency 3.
- ADDER_MCC_SUB_EN, WIDTH=32: x=5, y=7, sub=1 -> s={0, 0xFFFFFFFE}; x=7, y=5, sub=1 -> s={1, 0x00000002}.

Source files
------------

// File: rtl/adder_mcc_pipe.sv
// Pipelined Manchester-carry-chain adder: one SEG_W-bit carry chain per register stage.
// Optional subtract mode under `ADDER_MCC_SUB_EN`; default WIDTH taken from `WIDTH` (32 if undefined).
`ifndef WIDTH
`define WIDTH 32
`endif

module adder_mcc_pipe #(
    parameter int WIDTH = `WIDTH,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef ADDER_MCC_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
    output logic             busy
);

    localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

    // Manchester chain over segment k only: bits outside the segment return 0,
    // the MSB of the result is the segment's carry-out.
    function automatic logic [WIDTH:0] seg_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c_in,
        input int               k
    );
        logic [WIDTH-1:0] sum;
        logic             c;
        sum = '0;
        c   = c_in;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= k * SEG_W && i < (k + 1) * SEG_W) begin
                sum[i] = (a[i] ^ b[i]) ^ c;
                c      = (a[i] & b[i]) | ((a[i] | b[i]) & c);
            end
        end
        return {c, sum};
    endfunction

    logic [WIDTH-1:0] y_in;
    logic             c_in;

    // Subtraction is folded into the operands at accept, so the encoded
    // operand travels down the pipe with its transaction.
`ifdef ADDER_MCC_SUB_EN
    assign y_in = sub ? ~y : y;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign y_in = y;
    assign c_in = cin;
`endif

    logic [WIDTH-1:0] x_p   [NSEG];
    logic [WIDTH-1:0] y_p   [NSEG];
    logic [WIDTH-1:0] sum_p [NSEG];
    logic             c_p   [NSEG];
    logic             vld_p [NSEG];
    logic [WIDTH:0]   seg_res [NSEG];

    always_comb begin
        seg_res[0] = seg_add(x, y_in, c_in, 0);
        for (int k = 1; k < NSEG; k++) begin
            seg_res[k] = seg_add(x_p[k-1], y_p[k-1], c_p[k-1], k);
        end
    end

    assign out_valid = vld_p[NSEG-1];
    assign s         = {c_p[NSEG-1], sum_p[NSEG-1]};
    assign in_ready  = !(out_valid && !out_ready);

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            busy = busy | vld_p[k];
        end
    end

    // Stage k completes segment k; lower sum bits ride along already finished,
    // so every bit of a result leaves the last stage together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_p[k] <= 1'b0;
                c_p[k]   <= 1'b0;
                sum_p[k] <= '0;
                x_p[k]   <= '0;
                y_p[k]   <= '0;
            end
        end else if (in_ready) begin
            vld_p[0] <= in_valid;
            x_p[0]   <= x;
            y_p[0]   <= y_in;
            sum_p[0] <= seg_res[0][WIDTH-1:0];
            c_p[0]   <= seg_res[0][WIDTH];
            for (int k = 1; k < NSEG; k++) begin
                vld_p[k] <= vld_p[k-1];
                x_p[k]   <= x_p[k-1];
                y_p[k]   <= y_p[k-1];
                sum_p[k] <= seg_res[k][WIDTH-1:0] | sum_p[k-1];
                c_p[k]   <= seg_res[k][WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_adder_mcc_pipe.sv
// Bench for adder_mcc_pipe: a 32/8 instance and a 13/5 instance against an arithmetic model.
// Subtract vectors run only when ADDER_MCC_SUB_EN is defined.
module tb_adder_mcc_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_cin, a_sub, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_x, a_y;
    logic [32:0] a_s;
    logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_busy;
    logic [12:0] b_x, b_y;
    logic [13:0] b_s;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_a[$];
    logic [13:0] exp_b[$];

    adder_mcc_pipe #(.WIDTH(32), .SEG_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .cin(a_cin),
`ifdef ADDER_MCC_SUB_EN
        .sub(a_sub),
`endif
        .out_valid(a_out_valid), .out_ready(a_out_ready), .s(a_s), .busy(a_busy)
    );

    adder_mcc_pipe #(.WIDTH(13), .SEG_W(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .cin(b_cin),
`ifdef ADDER_MCC_SUB_EN
        .sub(b_sub),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready), .s(b_s), .busy(b_busy)
    );

    function automatic logic [32:0] ref32(input logic [31:0] xv, yv, input logic cv, sb);
        if (sb) return {1'b0, xv} + {1'b0, ~yv} + 33'd1;
        return {1'b0, xv} + {1'b0, yv} + {32'd0, cv};
    endfunction

    function automatic logic [13:0] ref13(input logic [12:0] xv, yv, input logic cv);
        return {1'b0, xv} + {1'b0, yv} + {13'd0, cv};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle of inputs at the falling edge and settle; no checking here.
    task automatic step_a(input logic iv, input logic [31:0] xv, yv,
                          input logic cv, sb, orv);
        @(negedge clk);
        a_in_valid = iv; a_x = xv; a_y = yv; a_cin = cv; a_sub = sb; a_out_ready = orv;
        #1;
    endtask

    task automatic step_b(input logic iv, input logic [12:0] xv, yv,
                          input logic cv, orv);
        @(negedge clk);
        b_in_valid = iv; b_x = xv; b_y = yv; b_cin = cv; b_sub = 1'b0; b_out_ready = orv;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step_a(1, 32'h1234, 32'h1, 0, 0, 1);
        step_b(1, 13'h5, 13'h6, 0, 1);
        step_a(0, 0, 0, 0, 0, 1);
        b_in_valid = 1'b0;
        rst = 1'b0;
        step_a(0, 0, 0, 0, 0, 1);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got=%b want=0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got=%b want=0", a_busy); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got=%b want=1", a_in_ready); end
        checks++; if (a_s !== 33'h0) begin errors++; $display("FAIL reset_a_s got=%h want=0", a_s); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got=%b want=0", b_out_valid); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got=%b want=0", b_busy); end
        checks++; if (b_s !== 14'h0) begin errors++; $display("FAIL reset_b_s got=%h want=0", b_s); end
    endtask

    task automatic test_ripple();
        int n;
        step_a(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 1);
        n = 0;
        do begin
            step_a(0, 0, 0, 0, 0, 1);
            n++;
        end while (!a_out_valid && n < 20);
        checks++; if (n !== 4) begin errors++; $display("FAIL ripple_latency got=%0d want=4", n); end
        checks++; if (a_s !== 33'h1_0000_0000) begin errors++; $display("FAIL ripple_sum got=%h want=100000000", a_s); end
        step_a(0, 0, 0, 0, 0, 1);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ripple_consumed got=%b want=0", a_out_valid); end
    endtask

    task automatic test_stream();
        logic [32:0] want [3];
        int first, got;
        want[0] = 33'h3; want[1] = 33'h1_0000_0000; want[2] = 33'h1_0000;
        step_a(1, 32'h1, 32'h2, 0, 0, 1);
        step_a(1, 32'h8000_0000, 32'h8000_0000, 0, 0, 1);
        step_a(1, 32'hFFFF, 32'h0, 1, 0, 1);
        first = -1; got = 0;
        for (int k = 0; k < 10; k++) begin
            step_a(0, 0, 0, 0, 0, 1);
            if (a_out_valid) begin
                if (first < 0) first = k;
                checks++;
                if (got > 2 || k != first + got) begin
                    errors++; $display("FAIL stream_order got=step%0d want=step%0d", k, first + got);
                end else if (a_s !== want[got]) begin
                    errors++; $display("FAIL stream_sum%0d got=%h want=%h", got, a_s, want[got]);
                end
                got++;
            end
        end
        checks++; if (first !== 1) begin errors++; $display("FAIL stream_first_step got=%0d want=1", first); end
        checks++; if (got !== 3) begin errors++; $display("FAIL stream_count got=%0d want=3", got); end
    endtask

    task automatic test_backpressure();
        int stalled, budget;
        logic [32:0] held_s;
        logic [31:0] xv, yv;
        logic        cv;
        stalled = 0; budget = 0; held_s = '0;
        while (stalled < 6 && budget < 40) begin
            xv = pick32(); yv = pick32(); cv = 1'($urandom_range(0, 1));
            step_a(1, xv, yv, cv, 0, 0);
            budget++;
            if (a_out_valid) begin
                if (stalled > 0) begin
                    checks++; if (a_s !== held_s) begin errors++; $display("FAIL bp_s_stable got=%h want=%h", a_s, held_s); end
                end
                checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", a_in_ready); end
                held_s = a_s;
                stalled++;
            end else if (stalled > 0) begin
                checks++; errors++; $display("FAIL bp_out_valid_dropped got=0 want=1");
            end
            if (a_in_valid && a_in_ready) exp_a.push_back(ref32(xv, yv, cv, 1'b0));
        end
        checks++; if (stalled < 6) begin errors++; $display("FAIL bp_never_stalled got=%0d want=6", stalled); end
        for (int k = 0; k < 20 && exp_a.size() > 0; k++) begin
            step_a(0, 0, 0, 0, 0, 1);
            if (a_out_valid) begin
                checks++;
                if (a_s !== exp_a[0]) begin errors++; $display("FAIL bp_drain got=%h want=%h", a_s, exp_a[0]); end
                void'(exp_a.pop_front());
            end
        end
        checks++; if (exp_a.size() !== 0) begin errors++; $display("FAIL bp_lost got=%0d want=0 pending", exp_a.size()); end
        step_a(0, 0, 0, 0, 0, 1);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate got=%b want=0", a_out_valid); end
    endtask

    task automatic test_reset_midflight();
        int n, spurious;
        step_a(1, 32'h10, 32'h20, 0, 0, 1);
        step_a(1, 32'h30, 32'h40, 1, 0, 1);
        rst = 1'b1;
        step_a(0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        step_a(0, 0, 0, 0, 0, 1);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", a_busy); end
        checks++; if (a_s !== 33'h0) begin errors++; $display("FAIL midrst_s got=%h want=0", a_s); end
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            step_a(0, 0, 0, 0, 0, 1);
            if (a_out_valid) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL midrst_spurious got=%0d want=0", spurious); end
        step_a(1, 32'd100, 32'd23, 1, 0, 1);
        n = 0;
        do begin
            step_a(0, 0, 0, 0, 0, 1);
            n++;
        end while (!a_out_valid && n < 20);
        checks++; if (n !== 4) begin errors++; $display("FAIL midrst_fresh_latency got=%0d want=4", n); end
        checks++; if (a_s !== 33'd124) begin errors++; $display("FAIL midrst_fresh_sum got=%h want=7c", a_s); end
        step_a(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_odd_width();
        int n;
        step_b(1, 13'h1FFF, 13'h1FFF, 1, 1);
        n = 0;
        do begin
            step_b(0, 0, 0, 0, 1);
            n++;
        end while (!b_out_valid && n < 20);
        checks++; if (n !== 3) begin errors++; $display("FAIL odd_latency got=%0d want=3", n); end
        checks++; if (b_s !== 14'h3FFF) begin errors++; $display("FAIL odd_sum got=%h want=3fff", b_s); end
        step_b(0, 0, 0, 0, 1);
    endtask

    task automatic test_random_a(input int cycles);
        logic        prev_stall, iv, cv, orv;
        logic [32:0] prev_s;
        logic [31:0] xv, yv;
        prev_stall = 1'b0; prev_s = '0;
        for (int i = 0; i < cycles; i++) begin
            iv = ($urandom_range(0, 3) != 0); orv = ($urandom_range(0, 3) != 0);
            xv = pick32(); yv = pick32(); cv = 1'($urandom_range(0, 1));
            step_a(iv, xv, yv, cv, 0, orv);
            if (prev_stall) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_s !== prev_s) begin
                    errors++; $display("FAIL rand_a_hold got=%b/%h want=1/%h", a_out_valid, a_s, prev_s);
                end
            end
            checks++;
            if (a_in_ready !== !(a_out_valid && !a_out_ready)) begin
                errors++; $display("FAIL rand_a_in_ready got=%b want=%b", a_in_ready, !(a_out_valid && !a_out_ready));
            end
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL rand_a_extra got=%h want=none", a_s);
                end else begin
                    if (a_s !== exp_a[0]) begin errors++; $display("FAIL rand_a_sum got=%h want=%h", a_s, exp_a[0]); end
                    void'(exp_a.pop_front());
                end
            end
            if (a_in_valid && a_in_ready) exp_a.push_back(ref32(xv, yv, cv, 1'b0));
            prev_stall = a_out_valid && !a_out_ready;
            prev_s = a_s;
        end
        for (int k = 0; k < 20 && exp_a.size() > 0; k++) begin
            step_a(0, 0, 0, 0, 0, 1);
            if (a_out_valid) begin
                checks++;
                if (a_s !== exp_a[0]) begin errors++; $display("FAIL rand_a_drain got=%h want=%h", a_s, exp_a[0]); end
                void'(exp_a.pop_front());
            end
        end
        checks++; if (exp_a.size() !== 0) begin errors++; $display("FAIL rand_a_pending got=%0d want=0", exp_a.size()); end
    endtask

    task automatic test_random_b(input int cycles);
        logic        iv, cv, orv;
        logic [12:0] xv, yv;
        for (int i = 0; i < cycles; i++) begin
            iv = ($urandom_range(0, 3) != 0); orv = ($urandom_range(0, 2) != 0);
            xv = 13'($urandom); yv = 13'($urandom); cv = 1'($urandom_range(0, 1));
            step_b(iv, xv, yv, cv, orv);
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL rand_b_extra got=%h want=none", b_s);
                end else begin
                    if (b_s !== exp_b[0]) begin errors++; $display("FAIL rand_b_sum got=%h want=%h", b_s, exp_b[0]); end
                    void'(exp_b.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) exp_b.push_back(ref13(xv, yv, cv));
        end
        for (int k = 0; k < 20 && exp_b.size() > 0; k++) begin
            step_b(0, 0, 0, 0, 1);
            if (b_out_valid) begin
                checks++;
                if (b_s !== exp_b[0]) begin errors++; $display("FAIL rand_b_drain got=%h want=%h", b_s, exp_b[0]); end
                void'(exp_b.pop_front());
            end
        end
        checks++; if (exp_b.size() !== 0) begin errors++; $display("FAIL rand_b_pending got=%0d want=0", exp_b.size()); end
    endtask

`ifdef ADDER_MCC_SUB_EN
    task automatic test_sub();
        logic [32:0] want [2];
        int got;
        want[0] = 33'h0_FFFF_FFFE; want[1] = 33'h1_0000_0002;
        step_a(1, 32'd5, 32'd7, 0, 1, 1);
        step_a(1, 32'd7, 32'd5, 1, 1, 1);
        got = 0;
        for (int k = 0; k < 10; k++) begin
            step_a(0, 0, 0, 0, 0, 1);
            if (a_out_valid && got < 2) begin
                checks++;
                if (a_s !== want[got]) begin errors++; $display("FAIL sub%0d got=%h want=%h", got, a_s, want[got]); end
                got++;
            end
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL sub_count got=%0d want=2", got); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_x = 0; a_y = 0; a_cin = 0; a_sub = 0; a_out_ready = 1;
        b_in_valid = 0; b_x = 0; b_y = 0; b_cin = 0; b_sub = 0; b_out_ready = 1;
        test_reset();
        test_ripple();
        test_stream();
        test_backpressure();
        test_reset_midflight();
        test_odd_width();
`ifdef ADDER_MCC_SUB_EN
        test_sub();
`endif
        test_random_a(300);
        test_random_b(300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
